mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter RD_LAT, default 2, meaning cycles from the ISSUE cycle to the cycle in which read data is valid on mem_bus.
REQ-002 The block SHALL have parameter WR_LAT, default 1, meaning WAIT cycles after ISSUE before the memory has committed the write.
REQ-003 The block SHALL have port CLK  input  1  system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RST  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port req[1:0]  input  2  per-requester request, held until ack; port 0 is instruction fetch, port 1 is data.
REQ-006 The block SHALL have port rw[1:0]  input  2  per-requester direction, 1 = read and 0 = write.
REQ-007 The block SHALL have port addr0, addr1  input  8 each  per-requester address.
REQ-008 The block SHALL have port wdata0, wdata1  input  8 each  per-requester write data.
REQ-009 The block SHALL have port ack[1:0]  output  2  one-cycle completion pulse per requester.
REQ-010 The block SHALL have port rdata  output  8  read data, valid while any ack bit is high.
REQ-011 The block SHALL have port mem_start  output  1  one-cycle memory command strobe.
REQ-012 The block SHALL have port mem_rw  output  1  command direction, 1 = read, valid with mem_start.
REQ-013 The block SHALL have port mem_addr  output  8  command address, valid with mem_start.
REQ-014 The block SHALL have port mem_bus  inout  8  shared memory data bus.
REQ-015 The block SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-016 The FSM SHALL have the states IDLE, ISSUE, WAIT and DONE.
REQ-017 In IDLE with any req bit high, the FSM SHALL latch the grant index and that requester's rw, addr and wdata, then go to ISSUE.
REQ-018 Arbitration SHALL be round-robin: if both requests are high, the requester not granted last wins; the last-grant pointer resets to 1, so port 0 wins the first tie.
REQ-019 ISSUE SHALL last exactly one cycle, with mem_start=1 and mem_rw/mem_addr taken from the latched values; the FSM then goes to WAIT.
REQ-020 WAIT SHALL last RD_LAT cycles for a read or WR_LAT cycles for a write, counted by an internal counter cleared on entry to WAIT.
REQ-021 For a read, rdata SHALL capture mem_bus on the rising edge that ends the last WAIT cycle.
REQ-022 For a write, the block SHALL drive mem_bus with the latched wdata during ISSUE and every WAIT cycle, and SHALL hold mem_bus at high impedance at all other times and for every read.
REQ-023 DONE SHALL last exactly one cycle with ack[grant]=1 and the other ack bit 0; the FSM then goes to IDLE.
REQ-024 Latency SHALL be: req high in IDLE cycle 0 gives ack in cycle RD_LAT+2 for a read and WR_LAT+2 for a write; the minimum gap between consecutive ISSUE cycles is one IDLE cycle.
REQ-025 rdata SHALL hold its last captured value until the next read capture; a write SHALL leave rdata unchanged.
REQ-026 Request inputs SHALL NOT be sampled outside IDLE; a req dropped mid-transaction SHALL NOT abort it, and ack is still pulsed.
REQ-027 A requester that keeps req high after its ack SHALL be treated as a new request at the next IDLE, subject to round-robin.
REQ-028 mem_start SHALL never be high for two consecutive cycles.

Reset
REQ-029 When RST=0, the block SHALL immediately force state=IDLE, ack=0, mem_start=0, mem_rw=1, mem_addr=0, rdata=0, busy=0, last-grant=1, counter=0 and mem_bus to high impedance.
REQ-030 Reset in any state SHALL abandon the transaction without an ack; after release the block SHALL take requests from IDLE on the first rising edge.

Structure
REQ-031 The state enum, port-index typedef and the default RD_LAT/WR_LAT constants SHALL reside in the shared package ay8_mem_pkg.
REQ-032 Round-robin selection SHALL be a combinational sub-module mem_rr_pick with inputs req[1:0] and last-grant and output grant index.

Verification
REQ-033 The bench SHALL cover: port1 write of 0x3C to 0x10 from IDLE cycle 0 -> mem_start in cycle 1, mem_bus=0x3C in cycles 1-2, ack[1] in cycle 3.
REQ-034 The bench SHALL cover: port0 read of 0x10 after that write -> mem_start in cycle 1, rdata=0x3C with ack[0] in cycle 4, and mem_bus high impedance from the block throughout.
REQ-035 The bench SHALL cover: both reqs held high continuously after reset (port0 reads 0x00, port1 reads 0x01) -> grants alternate 0,1,0,1, with no mem_start in consecutive cycles.
REQ-036 The bench SHALL cover: RST asserted during WAIT of a read -> no ack, busy=0 and mem_bus high impedance at once, and the next request completes normally.
REQ-037 The bench SHALL cover: req[0] dropped in the cycle after ISSUE -> ack[0] still pulses in cycle 4, and no new transaction starts.
REQ-038 The bench SHALL cover: RD_LAT=3 override -> read ack in cycle 5, with data sampled at the end of cycle 4.

Source files
------------

// File: rtl/ay8_mem_pkg.sv
// Shared types and default latencies for the two-port memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ay8_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Requester index: 0 = instruction fetch, 1 = data.
  typedef logic port_idx_t;

  localparam int RD_LAT_DEFAULT = 2;
  localparam int WR_LAT_DEFAULT = 1;

  // Width of the WAIT-cycle counter.
  localparam int LAT_W = 8;

  // One-hot ack pattern for a requester index.
  function automatic logic [1:0] port_onehot(port_idx_t p);
    return p ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-command signals of the arbiter, bundled.
// Latency: n/a (wires only).
// Backpressure: req is held by a requester until its ack pulse.
interface mem_arbiter_if;
  logic [1:0] req;
  logic [1:0] rw;
  logic [7:0] addr0;
  logic [7:0] addr1;
  logic [7:0] wdata0;
  logic [7:0] wdata1;
  logic [1:0] ack;
  logic [7:0] rdata;
  logic       mem_start;
  logic       mem_rw;
  logic [7:0] mem_addr;
  logic       busy;

  // The arbiter serves requests.
  modport slave (
    input  req, rw, addr0, addr1, wdata0, wdata1,
    output ack, rdata, mem_start, mem_rw, mem_addr, busy
  );

  // The requesters / memory side that observes commands.
  modport master (
    output req, rw, addr0, addr1, wdata0, wdata1,
    input  ack, rdata, mem_start, mem_rw, mem_addr, busy
  );
endinterface

// File: rtl/mem_rr_pick.sv
// Two-way round-robin choice between pending requesters.
// Latency: combinational.
// Backpressure: none; the caller decides when the pick is used.
module mem_rr_pick
  import ay8_mem_pkg::*;
(
  input  logic [1:0] req,
  input  port_idx_t  last_grant,
  output port_idx_t  grant
);

  // On a tie the port not served last wins; otherwise the only requester.
  always_comb begin
    grant = 1'b0;
    if (req == 2'b11) begin
      grant = ~last_grant;
    end else if (req[1]) begin
      grant = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two requesters onto one memory with a shared tristate data bus.
// Latency: ack RD_LAT+2 (read) / WR_LAT+2 (write) cycles after req seen in IDLE.
// Backpressure: requests are sampled only in IDLE; a requester holds req until ack.
module mem_arbiter
  import ay8_mem_pkg::*;
#(
  parameter int RD_LAT = RD_LAT_DEFAULT,
  parameter int WR_LAT = WR_LAT_DEFAULT
) (
  input  logic         CLK,
  input  logic         RST,
  mem_arbiter_if.slave arb,
  inout  wire  [7:0]   mem_bus
);

  // Counter value in the final WAIT cycle for each direction.
  localparam logic [LAT_W-1:0] RD_LAST = LAT_W'(RD_LAT - 1);
  localparam logic [LAT_W-1:0] WR_LAST = LAT_W'(WR_LAT - 1);

  state_t           state;
  state_t           state_nxt;
  port_idx_t        last_grant;
  port_idx_t        pick;
  logic             rw_q;
  logic [7:0]       addr_q;
  logic [7:0]       wdata_q;
  logic [7:0]       rdata_q;
  logic [LAT_W-1:0] cnt;
  logic             any_req;
  logic             wait_last;
  logic             drive;

  mem_rr_pick u_pick (
    .req        (arb.req),
    .last_grant (last_grant),
    .grant      (pick)
  );

  assign any_req   = |arb.req;
  assign wait_last = (cnt == (rw_q ? RD_LAST : WR_LAST));

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and per-state output decode.
  always_comb begin
    state_nxt     = state;
    arb.mem_start = 1'b0;
    arb.ack       = 2'b00;
    arb.busy      = 1'b1;
    drive         = 1'b0;
    case (state)
      IDLE: begin
        arb.busy = 1'b0;
        if (any_req) state_nxt = ISSUE;
      end
      ISSUE: begin
        arb.mem_start = 1'b1;
        drive         = ~rw_q;
        state_nxt     = WAIT;
      end
      WAIT: begin
        drive = ~rw_q;
        if (wait_last) state_nxt = DONE;
      end
      DONE: begin
        arb.ack   = port_onehot(last_grant);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the winner and its command; the grant doubles as the round-robin pointer.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      last_grant <= 1'b1;
      rw_q       <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else if (state == IDLE && any_req) begin
      last_grant <= pick;
      rw_q       <= arb.rw[pick];
      addr_q     <= pick ? arb.addr1 : arb.addr0;
      wdata_q    <= pick ? arb.wdata1 : arb.wdata0;
    end
  end

  // WAIT-cycle counter, cleared while in ISSUE so it starts at zero in WAIT.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt <= '0;
    end else if (state == ISSUE) begin
      cnt <= '0;
    end else if (state == WAIT) begin
      cnt <= cnt + LAT_W'(1);
    end
  end

  // Read data is taken off the bus on the edge that ends the last WAIT cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rdata_q <= '0;
    end else if (state == WAIT && rw_q && wait_last) begin
      rdata_q <= mem_bus;
    end
  end

  assign arb.rdata    = rdata_q;
  assign arb.mem_rw   = rw_q;
  assign arb.mem_addr = addr_q;
  assign mem_bus      = drive ? wdata_q : 8'hzz;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (default latencies and RD_LAT=3) share stimulus.
// A transaction-level model predicts acks, strobes, bus ownership and read data.
// The bench acts as the memory: it drives the bus whenever the arbiter must not.
module tb_mem_arbiter;
  import ay8_mem_pkg::*;

  logic CLK;
  logic RST;
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  logic [1:0] req, rw;
  logic [7:0] addr0, addr1, wdata0, wdata1;

  mem_arbiter_if ifa ();
  mem_arbiter_if ifb ();
  assign ifa.req = req;   assign ifa.rw = rw;
  assign ifa.addr0 = addr0; assign ifa.addr1 = addr1;
  assign ifa.wdata0 = wdata0; assign ifa.wdata1 = wdata1;
  assign ifb.req = req;   assign ifb.rw = rw;
  assign ifb.addr0 = addr0; assign ifb.addr1 = addr1;
  assign ifb.wdata0 = wdata0; assign ifb.wdata1 = wdata1;

  wire  [7:0] bus_a, bus_b;
  logic [1:0] tb_oe;
  logic [7:0] tb_val [2];
  assign bus_a = tb_oe[0] ? tb_val[0] : 8'hzz;
  assign bus_b = tb_oe[1] ? tb_val[1] : 8'hzz;

  mem_arbiter #(.RD_LAT(2), .WR_LAT(1)) dut_a (.CLK(CLK), .RST(RST), .arb(ifa.slave), .mem_bus(bus_a));
  mem_arbiter #(.RD_LAT(3), .WR_LAT(1)) dut_b (.CLK(CLK), .RST(RST), .arb(ifb.slave), .mem_bus(bus_b));

  // Transaction model, one slot per instance. Times are absolute cycle numbers.
  int         rd_lat_of [2];
  int         cyc;
  bit         m_act [2];
  int         m_iss [2], m_done [2], m_lat [2];
  bit         m_g [2], m_last [2], m_rw [2];
  logic [7:0] m_addr [2], m_wd [2], m_rd [2];
  logic [7:0] mem [2][256];
  logic [1:0] e_ack [2];
  logic       e_start [2], e_busy [2];
  logic [7:0] e_bus [2];
  int         passed, total;

  // Apply the rules at the edge that ends cycle cyc.
  task automatic model_edge(int k);
    if (m_act[k]) begin
      if (cyc == m_iss[k] + m_lat[k]) begin
        if (m_rw[k]) m_rd[k] = mem[k][m_addr[k]];
        else         mem[k][m_addr[k]] = m_wd[k];
      end
      if (cyc == m_done[k]) m_act[k] = 1'b0;
    end else if (req != 2'b00) begin
      m_g[k]    = (req == 2'b11) ? !m_last[k] : req[1];
      m_last[k] = m_g[k];
      m_rw[k]   = rw[m_g[k]];
      m_addr[k] = m_g[k] ? addr1 : addr0;
      m_wd[k]   = m_g[k] ? wdata1 : wdata0;
      m_lat[k]  = m_rw[k] ? rd_lat_of[k] : 1;
      m_iss[k]  = cyc + 1;
      m_done[k] = cyc + 2 + m_lat[k];
      m_act[k]  = 1'b1;
    end
  endtask

  // Expected outputs for the current cycle; also plays the memory on the bus.
  task automatic model_outputs(int k);
    bit drv;
    e_busy[k]  = m_act[k];
    e_start[k] = m_act[k] && cyc == m_iss[k];
    e_ack[k]   = (m_act[k] && cyc == m_done[k]) ? (m_g[k] ? 2'b10 : 2'b01) : 2'b00;
    drv = m_act[k] && !m_rw[k] && cyc >= m_iss[k] && cyc <= m_iss[k] + m_lat[k];
    if (drv) begin
      tb_oe[k] = 1'b0;
      e_bus[k] = m_wd[k];
    end else begin
      tb_oe[k]  = 1'b1;
      tb_val[k] = (m_act[k] && m_rw[k] && cyc == m_iss[k] + m_lat[k]) ? mem[k][m_addr[k]] : 8'h00;
      e_bus[k]  = tb_val[k];
    end
  endtask

  task automatic model_reset();
    RST = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_act[k] = 1'b0; m_last[k] = 1'b1; m_rd[k] = 8'h00;
      model_outputs(k);
    end
    #1;
  endtask

  // Advance one cycle; returns 1ns after the falling edge, outputs settled.
  task automatic tick();
    if (RST) begin model_edge(0); model_edge(1); end
    @(posedge CLK);
    cyc++;
    @(negedge CLK);
    model_outputs(0); model_outputs(1);
    #1;
  endtask

  task automatic drain();
    req = 2'b00;
    for (int i = 0; i < 20 && (m_act[0] || m_act[1]); i++) tick();
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) tick();
    total++; if (ifa.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", ifa.busy); else passed++;
    total++; if (ifa.ack !== 2'b00) $display("FAIL reset_ack: got %b want 00", ifa.ack); else passed++;
    total++; if (ifa.mem_start !== 1'b0) $display("FAIL reset_start: got %b want 0", ifa.mem_start); else passed++;
    total++; if (ifa.mem_rw !== 1'b1) $display("FAIL reset_mem_rw: got %b want 1", ifa.mem_rw); else passed++;
    total++; if (ifa.mem_addr !== 8'h00) $display("FAIL reset_mem_addr: got %h want 00", ifa.mem_addr); else passed++;
    total++; if (ifa.rdata !== 8'h00) $display("FAIL reset_rdata: got %h want 00", ifa.rdata); else passed++;
    total++; if (bus_a !== 8'h00) $display("FAIL reset_bus: got %h want 00", bus_a); else passed++;
    RST = 1'b1;
  endtask

  task automatic test_write();
    drain();
    req = 2'b10; rw = 2'b00; addr1 = 8'h10; wdata1 = 8'h3C; wdata0 = 8'h55;
    for (int i = 1; i <= 4; i++) begin
      tick();
      total++; if (ifa.mem_start !== (i == 1)) $display("FAIL wr_start c%0d: got %b want %b", i, ifa.mem_start, i == 1); else passed++;
      total++; if (bus_a !== ((i <= 2) ? 8'h3C : 8'h00)) $display("FAIL wr_bus c%0d: got %h want %h", i, bus_a, (i <= 2) ? 8'h3C : 8'h00); else passed++;
      total++; if (ifa.ack !== ((i == 3) ? 2'b10 : 2'b00)) $display("FAIL wr_ack c%0d: got %b want %b", i, ifa.ack, (i == 3) ? 2'b10 : 2'b00); else passed++;
      total++; if (ifa.busy !== (i <= 3)) $display("FAIL wr_busy c%0d: got %b want %b", i, ifa.busy, i <= 3); else passed++;
      if (i == 1) begin
        total++; if (ifa.mem_rw !== 1'b0 || ifa.mem_addr !== 8'h10) $display("FAIL wr_cmd: got rw=%b addr=%h want rw=0 addr=10", ifa.mem_rw, ifa.mem_addr); else passed++;
      end
      if (i == 3) begin
        total++; if (ifa.rdata !== 8'h00) $display("FAIL wr_rdata_kept: got %h want 00", ifa.rdata); else passed++;
        req = 2'b00;
      end
    end
  endtask

  task automatic test_read();
    drain();
    req = 2'b01; rw = 2'b01; addr0 = 8'h10; wdata0 = 8'hA5;
    for (int i = 1; i <= 5; i++) begin
      tick();
      total++; if (ifa.mem_start !== (i == 1)) $display("FAIL rd_start c%0d: got %b want %b", i, ifa.mem_start, i == 1); else passed++;
      total++; if (bus_a !== ((i == 3) ? 8'h3C : 8'h00)) $display("FAIL rd_bus c%0d: got %h want %h", i, bus_a, (i == 3) ? 8'h3C : 8'h00); else passed++;
      total++; if (ifa.ack !== ((i == 4) ? 2'b01 : 2'b00)) $display("FAIL rd_ack c%0d: got %b want %b", i, ifa.ack, (i == 4) ? 2'b01 : 2'b00); else passed++;
      if (i == 1) begin
        total++; if (ifa.mem_rw !== 1'b1 || ifa.mem_addr !== 8'h10) $display("FAIL rd_cmd: got rw=%b addr=%h want rw=1 addr=10", ifa.mem_rw, ifa.mem_addr); else passed++;
      end
      if (i == 4) begin
        total++; if (ifa.rdata !== 8'h3C) $display("FAIL rd_rdata: got %h want 3c", ifa.rdata); else passed++;
        req = 2'b00;
      end
    end
  endtask

  task automatic test_round_robin();
    int n;
    int consec;
    logic prev_start;
    logic [1:0] seen [4];
    model_reset();
    repeat (2) tick();
    RST = 1'b1;
    req = 2'b11; rw = 2'b11; addr0 = 8'h00; addr1 = 8'h01;
    n = 0; consec = 0; prev_start = 1'b0;
    for (int i = 0; i < 4; i++) seen[i] = 2'b00;
    for (int i = 1; i <= 21; i++) begin
      tick();
      if (ifa.mem_start && prev_start) consec++;
      prev_start = ifa.mem_start;
      total++; if (ifa.ack !== e_ack[0]) $display("FAIL rr_ack c%0d: got %b want %b", i, ifa.ack, e_ack[0]); else passed++;
      if (ifa.ack != 2'b00 && n < 4) begin
        seen[n] = ifa.ack;
        total++; if (ifa.rdata !== mem[0][n % 2]) $display("FAIL rr_rdata %0d: got %h want %h", n, ifa.rdata, mem[0][n % 2]); else passed++;
        n++;
      end
    end
    req = 2'b00;
    total++; if (n !== 4) $display("FAIL rr_count: got %0d want 4", n); else passed++;
    for (int i = 0; i < 4; i++) begin
      total++; if (seen[i] !== ((i % 2 == 1) ? 2'b10 : 2'b01)) $display("FAIL rr_order %0d: got %b want %b", i, seen[i], (i % 2 == 1) ? 2'b10 : 2'b01); else passed++;
    end
    total++; if (consec !== 0) $display("FAIL rr_start_gap: got %0d back-to-back strobes want 0", consec); else passed++;
  endtask

  task automatic test_reset_mid();
    drain();
    req = 2'b01; rw = 2'b01; addr0 = 8'h01; wdata0 = 8'h5A;
    repeat (2) tick();
    total++; if (ifa.busy !== 1'b1) $display("FAIL rst_rd_busy_before: got %b want 1", ifa.busy); else passed++;
    model_reset();
    total++; if (ifa.busy !== 1'b0 || ifa.ack !== 2'b00 || ifa.mem_start !== 1'b0) $display("FAIL rst_rd_now: got busy=%b ack=%b start=%b want 0/00/0", ifa.busy, ifa.ack, ifa.mem_start); else passed++;
    total++; if (bus_a !== 8'h00) $display("FAIL rst_rd_bus: got %h want 00", bus_a); else passed++;
    req = 2'b00;
    repeat (2) tick();
    total++; if (ifa.ack !== 2'b00 || ifa.busy !== 1'b0) $display("FAIL rst_rd_quiet: got ack=%b busy=%b want 00/0", ifa.ack, ifa.busy); else passed++;
    RST = 1'b1;
    req = 2'b10; rw = 2'b00; addr1 = 8'h20; wdata1 = 8'hC3;
    repeat (2) tick();
    total++; if (bus_a !== 8'hC3) $display("FAIL rst_wr_bus_before: got %h want c3", bus_a); else passed++;
    model_reset();
    total++; if (bus_a !== 8'h00 || ifa.busy !== 1'b0) $display("FAIL rst_wr_now: got bus=%h busy=%b want 00/0", bus_a, ifa.busy); else passed++;
    req = 2'b00;
    tick();
    RST = 1'b1;
    req = 2'b10; rw = 2'b10; addr1 = 8'h10; wdata1 = 8'h81;
    for (int i = 1; i <= 5; i++) begin
      tick();
      total++; if (ifa.ack !== ((i == 4) ? 2'b10 : 2'b00)) $display("FAIL rst_next_ack c%0d: got %b want %b", i, ifa.ack, (i == 4) ? 2'b10 : 2'b00); else passed++;
      if (i == 4) begin
        total++; if (ifa.rdata !== 8'h3C) $display("FAIL rst_next_rdata: got %h want 3c", ifa.rdata); else passed++;
        req = 2'b00;
      end
    end
  endtask

  task automatic test_drop_req();
    drain();
    req = 2'b01; rw = 2'b01; addr0 = 8'h10; wdata0 = 8'h77;
    for (int i = 1; i <= 8; i++) begin
      tick();
      total++; if (ifa.ack !== ((i == 4) ? 2'b01 : 2'b00)) $display("FAIL drop_ack c%0d: got %b want %b", i, ifa.ack, (i == 4) ? 2'b01 : 2'b00); else passed++;
      total++; if (ifa.mem_start !== (i == 1)) $display("FAIL drop_start c%0d: got %b want %b", i, ifa.mem_start, i == 1); else passed++;
      total++; if (ifa.busy !== (i <= 4)) $display("FAIL drop_busy c%0d: got %b want %b", i, ifa.busy, i <= 4); else passed++;
      if (i == 2) req = 2'b00;
    end
  endtask

  task automatic test_rd_lat3();
    logic [7:0] want;
    drain();
    req = 2'b01; rw = 2'b01; addr0 = 8'h44; wdata0 = 8'h99;
    want = mem[1][8'h44];
    for (int i = 1; i <= 6; i++) begin
      tick();
      total++; if (ifb.mem_start !== (i == 1)) $display("FAIL lat3_start c%0d: got %b want %b", i, ifb.mem_start, i == 1); else passed++;
      total++; if (ifb.ack !== ((i == 5) ? 2'b01 : 2'b00)) $display("FAIL lat3_ack c%0d: got %b want %b", i, ifb.ack, (i == 5) ? 2'b01 : 2'b00); else passed++;
      total++; if (bus_b !== ((i == 4) ? want : 8'h00)) $display("FAIL lat3_bus c%0d: got %h want %h", i, bus_b, (i == 4) ? want : 8'h00); else passed++;
      if (i == 5) begin
        total++; if (ifb.rdata !== want) $display("FAIL lat3_rdata: got %h want %h", ifb.rdata, want); else passed++;
        req = 2'b00;
      end
    end
  endtask

  task automatic test_random();
    drain();
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        req = 2'($urandom_range(0, 3)); rw = 2'($urandom_range(0, 3));
        addr0 = 8'($urandom); addr1 = 8'($urandom);
        wdata0 = 8'($urandom_range(1, 255)); wdata1 = 8'($urandom_range(1, 255));
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        logic [1:0] o_ack;
        logic       o_start, o_busy, o_rw;
        logic [7:0] o_bus, o_rd, o_addr;
        o_ack   = (k == 1) ? ifb.ack : ifa.ack;
        o_start = (k == 1) ? ifb.mem_start : ifa.mem_start;
        o_busy  = (k == 1) ? ifb.busy : ifa.busy;
        o_rw    = (k == 1) ? ifb.mem_rw : ifa.mem_rw;
        o_addr  = (k == 1) ? ifb.mem_addr : ifa.mem_addr;
        o_rd    = (k == 1) ? ifb.rdata : ifa.rdata;
        o_bus   = (k == 1) ? bus_b : bus_a;
        total++; if (o_ack !== e_ack[k]) $display("FAIL rnd_ack i%0d c%0d: got %b want %b", k, cyc, o_ack, e_ack[k]); else passed++;
        total++; if (o_start !== e_start[k]) $display("FAIL rnd_start i%0d c%0d: got %b want %b", k, cyc, o_start, e_start[k]); else passed++;
        total++; if (o_busy !== e_busy[k]) $display("FAIL rnd_busy i%0d c%0d: got %b want %b", k, cyc, o_busy, e_busy[k]); else passed++;
        total++; if (o_bus !== e_bus[k]) $display("FAIL rnd_bus i%0d c%0d: got %h want %h", k, cyc, o_bus, e_bus[k]); else passed++;
        total++; if (o_rd !== m_rd[k]) $display("FAIL rnd_rdata i%0d c%0d: got %h want %h", k, cyc, o_rd, m_rd[k]); else passed++;
        if (e_start[k]) begin
          total++; if (o_rw !== m_rw[k] || o_addr !== m_addr[k]) $display("FAIL rnd_cmd i%0d c%0d: got rw=%b addr=%h want rw=%b addr=%h", k, cyc, o_rw, o_addr, m_rw[k], m_addr[k]); else passed++;
        end
      end
    end
  endtask

  initial begin
    logic [7:0] v;
    RST = 1'b0;
    req = 2'b00; rw = 2'b00;
    addr0 = 8'h00; addr1 = 8'h00; wdata0 = 8'h00; wdata1 = 8'h00;
    tb_oe = 2'b11; tb_val[0] = 8'h00; tb_val[1] = 8'h00;
    rd_lat_of[0] = 2; rd_lat_of[1] = 3;
    cyc = 0; passed = 0; total = 0;
    for (int a = 0; a < 256; a++) begin
      v = 8'($urandom_range(1, 255));
      mem[0][a] = v;
      mem[1][a] = v;
    end
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_reset_mid();
    test_drop_req();
    test_rd_lat3();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
